// File: rtl/aes_key_pkg.sv
// Shared AES-128 key schedule definitions: round count, Rcon table, S-box and
// schedule FSM states.
package aes_key_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        AVAIL
    } key_state_t;

    // Rcon(i) for rounds 1..10; entry 0 is never used by the schedule.
    localparam logic [7:0] RCON [0:NR] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Byte 0x00 sits in the top byte, so byte b lives at bit offset 8*(255-b).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        return (i <= 4'(NR)) ? RCON[i] : 8'h00;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

endpackage

// File: rtl/inv_key_step.sv
// Combinational AES-128 reverse key-schedule step: derives round key i-1
// from round key i, where rcon_idx = i.
module inv_key_step
    import aes_key_pkg::*;
(
    input  logic [127:0] key,
    input  logic [3:0]   rcon_idx,
    output logic [127:0] prev_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p3;

    assign {w0, w1, w2, w3} = key;
    assign p3 = w3 ^ w2;

    // The recovered w3 feeds the g-function exactly as it did going forward.
    assign prev_key = {w0 ^ sub_rot_word(p3) ^ {rcon(rcon_idx), 24'h000000},
                       w1 ^ w0,
                       w2 ^ w1,
                       p3};

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 decryption key schedule: forward pass to round 10, then steps down on
// next_req. Define INV_KEY_CACHE_EN to serve reverse steps from a key cache.
module inv_key_schedule
    import aes_key_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         next_req,
    output logic [127:0] round_key_out,
    output logic [3:0]   round_idx_out,
    output logic         key_valid,
    output logic         busy
);

    localparam logic [3:0] LAST_FWD = 4'(NR - 1);

    key_state_t  state, next_state;
    logic [127:0] cur_key;
    logic [3:0]   cur_idx;
    logic [127:0] fwd_key;
    logic [127:0] prev_key;
    logic         do_step;
    logic [31:0]  f0, f1, f2, f3;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (key_load) begin
            next_state = FWD;
        end else begin
            case (state)
                FWD:     if (cur_idx == LAST_FWD) next_state = AVAIL;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        key_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            FWD:     busy = 1'b1;
            AVAIL:   key_valid = 1'b1;
            default: ;
        endcase
    end

    // Forward expansion from round cur_idx to cur_idx+1.
    assign f0 = cur_key[127:96] ^ sub_rot_word(cur_key[31:0]) ^ {rcon(cur_idx + 4'd1), 24'h000000};
    assign f1 = cur_key[95:64] ^ f0;
    assign f2 = cur_key[63:32] ^ f1;
    assign f3 = cur_key[31:0]  ^ f2;
    assign fwd_key = {f0, f1, f2, f3};

    assign do_step = (state == AVAIL) && next_req && !key_load && (cur_idx != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_key <= '0;
            cur_idx <= '0;
        end else if (key_load) begin
            cur_key <= key_in;
            cur_idx <= '0;
        end else if (state == FWD) begin
            cur_key <= fwd_key;
            cur_idx <= cur_idx + 4'd1;
        end else if (do_step) begin
            cur_key <= prev_key;
            cur_idx <= cur_idx - 4'd1;
        end
    end

`ifdef INV_KEY_CACHE_EN
    logic [127:0] key_cache [0:NR];

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (key_load)           key_cache[0] <= key_in;
            else if (state == FWD)  key_cache[cur_idx + 4'd1] <= fwd_key;
        end
    end

    assign prev_key = key_cache[cur_idx - 4'd1];
`else
    inv_key_step u_step (
        .key      (cur_key),
        .rcon_idx (cur_idx),
        .prev_key (prev_key)
    );
`endif

    assign round_key_out = cur_key;
    assign round_idx_out = cur_idx;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: a forward-expansion reference model
// queues expected outputs each cycle, which are popped after the clock edge.
module tb_inv_key_schedule;
    import aes_key_pkg::*;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         next_req = 1'b0;
    logic [127:0] round_key_out;
    logic [3:0]   round_idx_out;
    logic         key_valid;
    logic         busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic         check_data;
        logic         valid;
        logic         busy;
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t exp_q[$];

    key_state_t   m_state = IDLE;
    int           m_cnt = 0;
    int           m_idx = 0;
    logic [127:0] m_keys [0:10];

    always #5 clk = ~clk;

    inv_key_schedule dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .key_load      (key_load),
        .next_req      (next_req),
        .round_key_out (round_key_out),
        .round_idx_out (round_idx_out),
        .key_valid     (key_valid),
        .busy          (busy)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Forward expansion with Rcon generated by repeated xtime, not from a table.
    task automatic modelExpand(input logic [127:0] k);
        logic [7:0]  r;
        logic [31:0] w0, w1, w2, w3, t;
        m_keys[0] = k;
        r = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            {w0, w1, w2, w3} = m_keys[i-1];
            t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
            w0 = w0 ^ t ^ {r, 24'h0};
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            m_keys[i] = {w0, w1, w2, w3};
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic load, input logic [127:0] k, input logic nxt);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        key_load = load;
        key_in   = k;
        next_req = nxt;
        if (rst) begin
            m_state = IDLE;
            m_idx   = 0;
        end else if (load) begin
            modelExpand(k);
            m_state = FWD;
            m_cnt   = 0;
        end else if (m_state == FWD) begin
            m_cnt++;
            if (m_cnt == 10) begin
                m_state = AVAIL;
                m_idx   = 10;
            end
        end else if (m_state == AVAIL && nxt && m_idx > 0) begin
            m_idx--;
        end
        e.check_data = (m_state != FWD);
        e.valid      = (m_state == AVAIL);
        e.busy       = (m_state == FWD);
        e.idx        = (m_state == AVAIL) ? 4'(m_idx) : 4'd0;
        e.key        = (m_state == AVAIL) ? m_keys[m_idx] : '0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 128'd0, 128'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput("key_valid", 128'(key_valid), 128'(e.valid));
            checkOutput("busy", 128'(busy), 128'(e.busy));
            if (e.check_data) begin
                checkOutput("round_idx", 128'(round_idx_out), 128'(e.idx));
                checkOutput("round_key", round_key_out, e.key);
            end
        end
    endtask

    initial begin
        repeat (2) applyStimulus(1'b1, 1'b0, rand128(), 1'b0);
        checkOutput("reset_key", round_key_out, '0);

        // Full schedule for the FIPS-197 key, key_in scrambled when not loading.
        applyStimulus(1'b0, 1'b1, K1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, rand128(), 1'b0);
        checkOutput("k1_r10_valid", 128'(key_valid), 128'd1);
        checkOutput("k1_r10_idx", 128'(round_idx_out), 128'd10);
        checkOutput("k1_r10_key", round_key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
        checkOutput("k1_r9_idx", 128'(round_idx_out), 128'd9);
        checkOutput("k1_r9_key", round_key_out, 128'hac7766f319fadc2128d12941575c006e);

        for (int i = 8; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
            if (i == 1) checkOutput("k1_r1_key", round_key_out, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        checkOutput("k1_r0_key", round_key_out, K1);
        repeat (2) applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
        checkOutput("k1_r0_hold_idx", 128'(round_idx_out), 128'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, rand128(), 1'b0);

        // Restart mid-forward pass.
        applyStimulus(1'b0, 1'b1, K1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
        applyStimulus(1'b0, 1'b1, K2, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, rand128(), 1'b0);
        checkOutput("k2_r10_key", round_key_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset while available at idx 4, then next_req must do nothing.
        repeat (6) applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
        checkOutput("k2_r4_idx", 128'(round_idx_out), 128'd4);
        applyStimulus(1'b1, 1'b0, rand128(), 1'b1);
        checkOutput("reset_avail_valid", 128'(key_valid), 128'd0);
        repeat (2) applyStimulus(1'b0, 1'b0, rand128(), 1'b1);

        // key_load and next_req together: load wins.
        applyStimulus(1'b0, 1'b1, K2, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, rand128(), 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
        applyStimulus(1'b0, 1'b1, K1, 1'b1);
        checkOutput("collide_valid", 128'(key_valid), 128'd0);
        repeat (10) applyStimulus(1'b0, 1'b0, rand128(), 1'b1);
        checkOutput("collide_r10_key", round_key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Random keys walked down with irregular next_req.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b1, rand128(), 1'b0);
            repeat (10) applyStimulus(1'b0, 1'b0, rand128(), 1'b0);
            repeat (16) applyStimulus(1'b0, 1'b0, rand128(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: key_in  in  128  AES-128 cipher key, sampled only on key_load.
REQ-004 SHALL have ports: key_load  in  1  one-cycle pulse that starts a schedule.
REQ-005 SHALL have ports: next_req  in  1  request for the next lower round key.
REQ-006 SHALL have ports: round_key_out  out  128  current decryption round key.
REQ-007 SHALL have ports: round_idx_out  out  4  AES round index of round_key_out (10 down to 0).
REQ-008 SHALL have ports: key_valid  out  1  round_key_out and round_idx_out are valid.
REQ-009 SHALL have ports: busy  out  1  forward pass in progress.

Function
REQ-010 SHALL use FSM states: IDLE, FWD, AVAIL.
- IDLE: key_valid=0, busy=0.
- FWD: busy=1, one forward AES-128 expansion round per cycle, rounds 1..10, with Rcon(i) = 01,02,04,08,10,20,40,80,1B,36.
- AVAIL: key_valid=1, busy=0.
REQ-011 SHALL capture key_in on the key_load cycle t, enter FWD, and assert key_valid at cycle t+11 with round_idx_out=10 and round_key_out=round-10 key.
REQ-012 SHALL, in AVAIL with round_idx_out=i>0 and next_req=1, present round key i-1 and index i-1 on the next cycle; key_valid stays high; one step per cycle when next_req is held.
REQ-013 SHALL compute the inverse step with words w0..w3 (w0 = bits 127:96), from key i to key i-1:
- w3' = w3^w2
- w2' = w2^w1
- w1' = w1^w0
- w0' = w0 ^ SubWord(RotWord(w3')) ^ (Rcon(i)<<24)
REQ-014 SHALL ignore next_req when round_idx_out=0; the outputs hold until key_load or reset.
REQ-015 SHALL ignore next_req while in IDLE or FWD.
REQ-016 SHALL treat key_load in any state, including mid-FWD and AVAIL, as a restart:
- capture the new key;
- key_valid drops the next cycle;
- latency is per REQ-011.
REQ-017 SHALL give key_load priority over next_req in the same cycle.
REQ-018 SHALL hold round_key_out and round_idx_out stable whenever no step or load occurs.

Reset
REQ-019 SHALL, on reset, enter IDLE and drive round_key_out=0, round_idx_out=0, key_valid=0, busy=0, with the internal key register cleared.
REQ-020 SHALL give reset priority over key_load and next_req; reset mid-FWD aborts with no valid output.

Configuration
REQ-021 SHALL support macro INV_KEY_CACHE_EN.
- When defined: all 11 round keys are stored in a register array during FWD, and reverse steps read the array instead of computing REQ-013.
- When undefined: no array; reverse steps are computed by REQ-013 logic.
- Port-visible behaviour and cycle timing are identical in both builds.

Structure
REQ-022 SHALL place the following in shared package aes_key_pkg:
- NR=10 constant;
- Rcon table;
- sbox function;
- FSM state enum.
REQ-023 SHALL place the combinational inverse round step (REQ-013) in sub-module inv_key_step (inputs: key, rcon index; output: previous key).

Verification
REQ-024 Scenario: key_in=2b7e151628aed2a6abf7158809cf4f3c, key_load at cycle t -> at cycle t+11, key_valid=1, idx=10, key=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-025 Scenario: same key, one next_req after key_valid -> idx=9, key=ac7766f319fadc2128d12941575c006e.
REQ-026 Scenario: next_req held high for 10 cycles -> idx 9..0, with key=a0fafe1788542cb123a339392a6c7605 at idx=1 and 2b7e151628aed2a6abf7158809cf4f3c at idx=0; further next_req leaves idx=0.
REQ-027 Scenario: key_load of key 000102030405060708090a0b0c0d0e0f at cycle t+5 of a prior FWD -> valid at (t+5)+11 with round-10 key 13111d7fe3944a17f307a78b4d2b30c5; no intermediate key_valid.
REQ-028 Scenario: reset asserted in AVAIL at idx=4 -> next cycle all outputs 0, state IDLE; next_req then has no effect.
REQ-029 Scenario: key_load and next_req in the same AVAIL cycle -> restart occurs, key_valid=0 next cycle, no step taken; both INV_KEY_CACHE_EN builds give identical traces.
